// File: rtl/net_packet_s_injector_pkg.sv
// net_packet_s_injector_pkg
//   Shared net_packet_s network definitions: the packet and boot-image entry
//   layouts, the network opcode enum, and the injector state encoding.
//   It also holds format_packet(), the field-formatting mux applied when an
//   image entry becomes a packet. The logger and scoreboards reuse it.
package net_packet_s_injector_pkg;

  localparam int unsigned id_width_gp       = 10;
  localparam int unsigned net_addr_width_gp = 16;
  localparam int unsigned net_data_width_gp = 32;
  localparam int unsigned imem_addr_width_gp = 10;
  localparam int unsigned rs_imm_size_gp    = 5;
  localparam int unsigned mask_length_gp    = 8;

  // Network opcodes; codes 5..7 are illegal in a boot image.
  typedef enum logic [2:0] {
    NET_NULL  = 3'd0,
    NET_INSTR = 3'd1,
    NET_REG   = 3'd2,
    NET_PC    = 3'd3,
    NET_BAR   = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_s;

  typedef struct packed {
    logic [id_width_gp-1:0]       ID;
    net_op_e                      net_op;
    logic [net_addr_width_gp-1:0] net_addr;
    logic [net_data_width_gp-1:0] net_data;
  } net_packet_s;

  // One boot-image ROM word: a packet without its destination ID.
  typedef struct packed {
    net_op_e                      net_op;
    logic [net_addr_width_gp-1:0] net_addr;
    logic [net_data_width_gp-1:0] net_data;
  } net_image_entry_s;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_DECODE = 3'd2,
    ST_SEND   = 3'd3,
    ST_DONE   = 3'd4
  } net_inj_state_e;

  localparam logic [net_addr_width_gp-1:0] imem_addr_mask_gp =
    net_addr_width_gp'((64'd1 << imem_addr_width_gp) - 64'd1);
  localparam logic [net_addr_width_gp-1:0] rs_imm_mask_gp =
    net_addr_width_gp'((64'd1 << rs_imm_size_gp) - 64'd1);
  localparam logic [net_data_width_gp-1:0] instr_data_mask_gp =
    net_data_width_gp'((64'd1 << $bits(instruction_s)) - 64'd1);
  localparam logic [net_data_width_gp-1:0] bar_mask_gp =
    net_data_width_gp'((64'd1 << mask_length_gp) - 64'd1);

  // Build the outgoing packet for a legal entry. Each opcode truncates its
  // fields to the widths the receiving core actually decodes. Illegal
  // opcodes yield an all-zero NULL packet.
  function automatic net_packet_s format_packet(input net_image_entry_s entry,
                                                input logic [id_width_gp-1:0] id);
    net_packet_s pkt;
    pkt        = '0;
    pkt.ID     = id;
    pkt.net_op = entry.net_op;
    case (entry.net_op)
      NET_INSTR: begin
        pkt.net_addr = entry.net_addr & imem_addr_mask_gp;
        pkt.net_data = entry.net_data & instr_data_mask_gp;
      end
      NET_REG: begin
        pkt.net_addr = entry.net_addr & rs_imm_mask_gp;
        pkt.net_data = entry.net_data;
      end
      NET_BAR: begin
        pkt.net_addr = '0;
        pkt.net_data = entry.net_data & bar_mask_gp;
      end
      NET_PC: begin
        pkt.net_addr = entry.net_addr & imem_addr_mask_gp;
        pkt.net_data = entry.net_data & bar_mask_gp;
      end
      default: begin
        pkt = '0;
      end
    endcase
    return pkt;
  endfunction

endpackage

// File: rtl/net_packet_s_injector_if.sv
// net_packet_s_injector_if
//   Network link from the injector (master) to a core's network input (slave).
//   net_packet : presented packet; valid whenever net_op != NET_NULL.
//   ready      : slave accepts the presented packet on this rising edge.
interface net_packet_s_injector_if;
  import net_packet_s_injector_pkg::*;

  net_packet_s net_packet;
  logic        ready;

  modport master (output net_packet, input ready);
  modport slave  (input net_packet, output ready);
endinterface

// File: rtl/net_packet_s_injector.sv
// net_packet_s_injector
//   Walks a boot image held in a synchronous ROM. Each entry becomes one
//   net_packet_s sent toward a core. A NULL entry ends the stream.
//   Ports:
//     clk          clock
//     reset        asynchronous active-low reset
//     start_i      begin streaming; honoured only in IDLE or DONE
//     core_id_i    destination ID, latched on start
//     img_addr_o   registered ROM read address
//     img_data_i   ROM word, valid the cycle after img_addr_o
//     net_if       packet/ready link (master side)
//     busy_o       high in ISSUE, DECODE and SEND
//     done_o       high in DONE
//     error_o      illegal opcode or image overrun; sticky until next start
//     pkt_count_o  packets accepted since start, saturating
//   id_width_p must equal id_width_gp, the ID width in net_packet_s.
module net_packet_s_injector
  import net_packet_s_injector_pkg::*;
#(
  parameter int unsigned img_addr_width_p = 10,
  parameter int unsigned id_width_p       = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start_i,
  input  logic [id_width_p-1:0]                core_id_i,
  output logic [img_addr_width_p-1:0]          img_addr_o,
  input  logic [$bits(net_image_entry_s)-1:0]  img_data_i,
  net_packet_s_injector_if.master              net_if,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 error_o,
  output logic [15:0]                          pkt_count_o
);

  localparam logic [img_addr_width_p-1:0] addr_last_lp = '1;
  localparam logic [img_addr_width_p-1:0] addr_one_lp  = img_addr_width_p'(1);

  net_inj_state_e                state_r;
  logic [id_width_gp-1:0]        id_r;
  logic [img_addr_width_p-1:0]   img_addr_r;
  net_packet_s                   net_packet_r;
  logic                          busy_r;
  logic                          done_r;
  logic                          error_r;
  logic [15:0]                   pkt_count_r;
  net_image_entry_s              entry_s;

  assign entry_s = net_image_entry_s'(img_data_i);

  // Injector FSM. All outputs are registered here. An entry is "consumed"
  // once it is accepted or skipped. Consuming the last ROM word ends the
  // stream with an error rather than wrapping the address to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      id_r         <= '0;
      img_addr_r   <= '0;
      net_packet_r <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      pkt_count_r  <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            id_r        <= core_id_i;
            img_addr_r  <= '0;
            pkt_count_r <= 16'd0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= ST_ISSUE;
          end else begin
            state_r <= state_r;
          end
        end

        // Address was set on the previous edge; the ROM captures it now.
        ST_ISSUE: begin
          state_r <= ST_DECODE;
        end

        ST_DECODE: begin
          case (entry_s.net_op)
            NET_NULL: begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end
            NET_INSTR, NET_REG, NET_BAR, NET_PC: begin
              net_packet_r <= format_packet(entry_s, id_r);
              state_r      <= ST_SEND;
            end
            default: begin
              error_r <= 1'b1;
              if (img_addr_r == addr_last_lp) begin
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
                state_r <= ST_DONE;
              end else begin
                img_addr_r <= img_addr_r + addr_one_lp;
                state_r    <= ST_ISSUE;
              end
            end
          endcase
        end

        // Packet is held with no timeout until the core takes it.
        ST_SEND: begin
          if (net_if.ready) begin
            net_packet_r <= '0;
            if (pkt_count_r != 16'hFFFF) begin
              pkt_count_r <= pkt_count_r + 16'd1;
            end else begin
              pkt_count_r <= pkt_count_r;
            end
            if (img_addr_r == addr_last_lp) begin
              error_r <= 1'b1;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              img_addr_r <= img_addr_r + addr_one_lp;
              state_r    <= ST_ISSUE;
            end
          end else begin
            state_r <= ST_SEND;
          end
        end

        default: begin
          net_packet_r <= '0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign img_addr_o        = img_addr_r;
  assign net_if.net_packet = net_packet_r;
  assign busy_o            = busy_r;
  assign done_o            = done_r;
  assign error_o           = error_r;
  assign pkt_count_o       = pkt_count_r;

endmodule

// File: tb/tb_net_packet_s_injector.sv
module tb_net_packet_s_injector;
  import net_packet_s_injector_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic        start2_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [9:0]  core_id_i = 10'd0;

  logic [9:0]  img_addr_o;
  logic [1:0]  img_addr2_o;
  logic [50:0] img_data;
  logic [50:0] img_data2;
  logic        busy_o, done_o, error_o;
  logic        busy2_o, done2_o, error2_o;
  logic [15:0] pkt_count_o, pkt_count2_o;

  logic [50:0] rom  [0:1023];
  logic [50:0] rom2 [0:3];

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  net_packet_s_injector_if net_if ();
  net_packet_s_injector_if net_if2 ();
  assign net_if.ready  = ready_i;
  assign net_if2.ready = ready_i;

  net_packet_s_injector #(.img_addr_width_p(10), .id_width_p(10)) u_dut (
    .clk(clk), .reset(reset), .start_i(start_i), .core_id_i(core_id_i),
    .img_addr_o(img_addr_o), .img_data_i(img_data), .net_if(net_if),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .pkt_count_o(pkt_count_o)
  );

  net_packet_s_injector #(.img_addr_width_p(2), .id_width_p(10)) u_dut2 (
    .clk(clk), .reset(reset), .start_i(start2_i), .core_id_i(core_id_i),
    .img_addr_o(img_addr2_o), .img_data_i(img_data2), .net_if(net_if2),
    .busy_o(busy2_o), .done_o(done2_o), .error_o(error2_o), .pkt_count_o(pkt_count2_o)
  );

  always #5 clk = ~clk;

  // synchronous ROM models
  always @(posedge clk) begin
    img_data  <= rom[img_addr_o];
    img_data2 <= rom2[img_addr2_o];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mkpkt(input logic [9:0] id, input logic [2:0] op,
                                        input logic [15:0] a, input logic [31:0] d);
    return {3'b000, id, op, a, d};
  endfunction

  function automatic logic [50:0] mkent(input logic [2:0] op, input logic [15:0] a,
                                        input logic [31:0] d);
    return {op, a, d};
  endfunction

  task automatic load_image1;
    rom[0] = mkent(NET_INSTR, 16'h0003, 32'h1234_5678);
    rom[1] = mkent(NET_REG,   16'h0005, 32'hDEAD_BEEF);
    rom[2] = mkent(NET_PC,    16'h0010, 32'h0000_0001);
    rom[3] = mkent(NET_NULL,  16'h0000, 32'h0000_0000);
  endtask

  // start pulse; returns just after the edge that enters ISSUE
  task automatic start_dut(input logic [9:0] id);
    core_id_i = id;
    start_i   = 1'b1;
    step;
    start_i   = 1'b0;
    exp_cnt   = 0;
    chk("start_busy",  64'(busy_o), 64'd1);
    chk("start_done",  64'(done_o), 64'd0);
    chk("start_err",   64'(error_o), 64'd0);
    chk("start_cnt",   64'(pkt_count_o), 64'd0);
    chk("start_addr",  64'(img_addr_o), 64'd0);
  endtask

  // from ISSUE: DECODE (null), SEND (packet, held for stall cycles), accept
  task automatic run_packet(input string tag, input logic [63:0] exp, input int stall);
    ready_i = (stall == 0);
    step;
    chk({tag, "_gap"}, 64'(net_if.net_packet.net_op), 64'(NET_NULL));
    step;
    chk(tag, 64'(net_if.net_packet), exp);
    chk({tag, "_cnt_before"}, 64'(pkt_count_o), 64'(exp_cnt));
    for (int i = 0; i < stall; i++) begin
      step;
      chk({tag, "_hold"}, 64'(net_if.net_packet), exp);
    end
    ready_i = 1'b1;
    step;
    exp_cnt++;
    chk({tag, "_null_after"}, 64'(net_if.net_packet.net_op), 64'(NET_NULL));
    chk({tag, "_cnt_after"}, 64'(pkt_count_o), 64'(exp_cnt));
  endtask

  // from ISSUE of the NULL terminator: DECODE then DONE
  task automatic finish_stream(input logic exp_err);
    step;
    chk("term_busy", 64'(busy_o), 64'd1);
    step;
    chk("done_done", 64'(done_o), 64'd1);
    chk("done_busy", 64'(busy_o), 64'd0);
    chk("done_cnt",  64'(pkt_count_o), 64'(exp_cnt));
    chk("done_err",  64'(error_o), 64'(exp_err));
    chk("done_op",   64'(net_if.net_packet.net_op), 64'(NET_NULL));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    for (int i = 0; i < 4; i++) rom2[i] = mkent(NET_BAR, 16'h1234, 32'hFFFF_FFFF);
    load_image1();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pkt",   64'(net_if.net_packet), 64'd0);
    chk("rst_addr",  64'(img_addr_o), 64'd0);
    chk("rst_busy",  64'(busy_o), 64'd0);
    chk("rst_done",  64'(done_o), 64'd0);
    chk("rst_err",   64'(error_o), 64'd0);
    chk("rst_cnt",   64'(pkt_count_o), 64'd0);
    chk("rst_pkt2",  64'(net_if2.net_packet), 64'd0);
    reset = 1'b1;
    step;
    chk("idle_busy", 64'(busy_o), 64'd0);

    // normal stream, ready always high
    start_dut(10'h02A);
    run_packet("t1_instr", mkpkt(10'h02A, NET_INSTR, 16'h0003, 32'h1234_5678), 0);
    run_packet("t1_reg",   mkpkt(10'h02A, NET_REG,   16'h0005, 32'hDEAD_BEEF), 0);
    run_packet("t1_pc",    mkpkt(10'h02A, NET_PC,    16'h0010, 32'h0000_0001), 0);
    finish_stream(1'b0);

    // backpressure: REG stalled five cycles
    start_dut(10'h02A);
    run_packet("t2_instr", mkpkt(10'h02A, NET_INSTR, 16'h0003, 32'h1234_5678), 0);
    run_packet("t2_reg",   mkpkt(10'h02A, NET_REG,   16'h0005, 32'hDEAD_BEEF), 5);
    run_packet("t2_pc",    mkpkt(10'h02A, NET_PC,    16'h0010, 32'h0000_0001), 0);
    finish_stream(1'b0);

    // illegal opcode entry is skipped
    rom[1] = mkent(3'd6, 16'h0044, 32'h0000_0000);
    rom[2] = mkent(NET_PC, 16'h0010, 32'h0000_0001);
    rom[3] = mkent(NET_NULL, 16'h0000, 32'h0000_0000);
    start_dut(10'h02A);
    run_packet("t3_instr", mkpkt(10'h02A, NET_INSTR, 16'h0003, 32'h1234_5678), 0);
    step;
    chk("t3_skip_dec_op", 64'(net_if.net_packet.net_op), 64'(NET_NULL));
    step;
    chk("t3_skip_err",  64'(error_o), 64'd1);
    chk("t3_skip_addr", 64'(img_addr_o), 64'd2);
    chk("t3_skip_op",   64'(net_if.net_packet.net_op), 64'(NET_NULL));
    chk("t3_skip_busy", 64'(busy_o), 64'd1);
    run_packet("t3_pc", mkpkt(10'h02A, NET_PC, 16'h0010, 32'h0000_0001), 0);
    finish_stream(1'b1);
    chk("t3_total", 64'(pkt_count_o), 64'd2);

    // reset while a packet is held in SEND
    load_image1();
    start_dut(10'h02A);
    ready_i = 1'b0;
    step;
    step;
    chk("t4_presend", 64'(net_if.net_packet), mkpkt(10'h02A, NET_INSTR, 16'h0003, 32'h1234_5678));
    #2;
    reset = 1'b0;
    #1;
    chk("t4_rst_op",   64'(net_if.net_packet.net_op), 64'(NET_NULL));
    chk("t4_rst_pkt",  64'(net_if.net_packet), 64'd0);
    chk("t4_rst_busy", 64'(busy_o), 64'd0);
    chk("t4_rst_addr", 64'(img_addr_o), 64'd0);
    chk("t4_rst_cnt",  64'(pkt_count_o), 64'd0);
    #3;
    reset   = 1'b1;
    ready_i = 1'b1;
    step;

    // restart; start_i held high while busy must be ignored
    start_dut(10'h02A);
    core_id_i = 10'h3FF;
    start_i   = 1'b1;
    run_packet("t5_instr", mkpkt(10'h02A, NET_INSTR, 16'h0003, 32'h1234_5678), 0);
    start_i   = 1'b0;
    run_packet("t5_reg",   mkpkt(10'h02A, NET_REG,   16'h0005, 32'hDEAD_BEEF), 0);
    run_packet("t5_pc",    mkpkt(10'h02A, NET_PC,    16'h0010, 32'h0000_0001), 0);
    finish_stream(1'b0);

    // restart from DONE with a new destination
    start_dut(10'h155);
    run_packet("t6_instr", mkpkt(10'h155, NET_INSTR, 16'h0003, 32'h1234_5678), 0);
    run_packet("t6_reg",   mkpkt(10'h155, NET_REG,   16'h0005, 32'hDEAD_BEEF), 0);
    run_packet("t6_pc",    mkpkt(10'h155, NET_PC,    16'h0010, 32'h0000_0001), 0);
    finish_stream(1'b0);

    // image without terminator on a 4-entry ROM
    core_id_i = 10'h0AA;
    start2_i  = 1'b1;
    step;
    start2_i  = 1'b0;
    chk("t7_start_busy", 64'(busy2_o), 64'd1);
    for (int k = 0; k < 4; k++) begin
      step;
      chk("t7_gap", 64'(net_if2.net_packet.net_op), 64'(NET_NULL));
      step;
      chk("t7_bar", 64'(net_if2.net_packet), mkpkt(10'h0AA, NET_BAR, 16'h0000, 32'h0000_00FF));
      step;
      chk("t7_cnt", 64'(pkt_count2_o), 64'(k + 1));
    end
    chk("t7_done", 64'(done2_o), 64'd1);
    chk("t7_err",  64'(error2_o), 64'd1);
    chk("t7_busy", 64'(busy2_o), 64'd0);
    chk("t7_addr", 64'(img_addr2_o), 64'd3);
    chk("t7_op",   64'(net_if2.net_packet.net_op), 64'(NET_NULL));
    step;
    chk("t7_stay_done", 64'(done2_o), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/net_packet_s_injector.md
Name: net_packet_s_injector

Overview:
- Transmit end of the net_packet_s network: walks a boot image in a synchronous ROM and drives net_packet_s packets toward a core.
- Packet types are INSTR (IMEM writes), REG (register writes), BAR (barrier mask) and PC (start PC plus barrier).
- Produces exactly the traffic the packet logger decodes.
- Sits between the test/boot harness and a core's network input port. A packet is valid when net_op != NULL.

Parameters:
- img_addr_width_p, 10, ROM address width; the image holds at most 2^img_addr_width_p entries.
- id_width_p, 10, width of the core_id_i field and of net_packet_s.ID.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start_i  in  1  begin streaming the image; sampled in IDLE or DONE only.
- core_id_i  in  id_width_p  destination ID, latched on start.
- ready_i  in  1  downstream accepts the presented packet on this rising edge.
- img_addr_o  out  img_addr_width_p  ROM read address (registered).
- img_data_i  in  $bits(net_image_entry_s)  ROM data; valid one cycle after img_addr_o.
- net_packet_o  out  $bits(net_packet_s)  outgoing packet (registered).
- busy_o  out  1  high from start until DONE.
- done_o  out  1  high in DONE.
- error_o  out  1  sticky until the next start.
- pkt_count_o  out  16  number of packets accepted since start.

Behaviour:
- Reset (async, low): state IDLE. net_packet_o is all zero (net_op=NULL). img_addr_o, busy_o, done_o, error_o and pkt_count_o are all 0.
- States are IDLE, ISSUE, DECODE, SEND and DONE.
- IDLE/DONE, start_i=1: latch core_id_i into ID. Clear img_addr_o, pkt_count_o, done_o and error_o. Go to ISSUE. start_i in any other state is ignored.
- ISSUE (1 cycle): img_addr_o is stable. Go to DECODE.
- DECODE: sample img_data_i as an entry {op, addr, data}.
  - op==NULL: terminator; go to DONE.
  - op is INSTR/REG/BAR/PC: load the net_packet_o fields and go to SEND.
  - Any other op: set error_o, skip the entry (advance address) and go to ISSUE.
- Field formatting on load:
  - INSTR: addr masked to imem_addr_width_gp bits; data masked to $bits(instruction_s).
  - REG: addr masked to rs_imm_size_gp bits; data unmasked.
  - BAR: addr forced to 0; data masked to mask_length_gp.
  - PC: addr masked to imem_addr_width_gp; data masked to mask_length_gp.
- SEND: net_packet_o is held constant while ready_i=0, with no timeout. On the edge where ready_i=1:
  - pkt_count_o increments, saturating at 0xFFFF.
  - net_packet_o.net_op goes to NULL (other fields are don't-care; drive them to 0).
  - img_addr_o increments and the state goes to ISSUE.
- Address wrap: if an entry is consumed (accepted or skipped) at address 2^img_addr_width_p-1, go to DONE with error_o=1. The address never wraps to 0.
- DONE: busy_o=0, done_o=1, net_packet_o.net_op=NULL. Restartable by start_i.
- busy_o=1 in ISSUE, DECODE and SEND.
- Throughput: 3 cycles per packet when ready_i stays high. A NULL packet is always present for at least 2 cycles between packets.
- Reset mid-SEND: net_op drops to NULL asynchronously and the packet is discarded; nothing is replayed.

Decomposition:
- Shared package (with net_packet_s, the net_op enum, imem_addr_width_gp, rs_imm_size_gp, mask_length_gp and instruction_s):
  - add typedef net_image_entry_s {net_op, net_addr, net_data}, matching net_packet_s widths without ID;
  - add the state enum net_inj_state_e.
- No sub-module. The field-formatting mux is a function in the package so the logger/scoreboard can reuse it.

Test Plan:
- Image [INSTR a=0x0003 d=0x12345678; REG a=0x5 d=0xDEADBEEF; PC a=0x0010 d=0x1; NULL], core_id_i=0x02A, ready_i=1:
  - 3 packets, each 3 cycles apart, ID=0x02A, fields exactly as given;
  - done_o=1; pkt_count_o=3; error_o=0.
- Same image, ready_i low for 5 cycles during the REG packet: REG is held unchanged for 5 extra cycles, then accepted; the sequence is otherwise identical.
- Entry with an illegal op between INSTR and PC: it is skipped, error_o=1, and 2 packets are sent.
- Image with no NULL (img_addr_width_p=2, four BAR entries, data 0xFFFFFFFF): 4 BAR packets, each with data masked to mask_length_gp and addr=0; then DONE with error_o=1.
- Reset asserted while in SEND: net_op=NULL immediately and all outputs 0. The following start re-sends from address 0 with pkt_count_o starting at 0.
- start_i pulsed during busy: no effect. start_i in DONE: the stream repeats with the new core_id_i.
